// File: rtl/spio_ctrl_reg_bank_mc.sv
// Multi-channel SpiNNaker control/diagnostic register bank with pipelined bus and write lock.
// Optional SHADOW_COMMIT_EN: channel analog writes are staged and applied together by COMMIT.
module spio_ctrl_reg_bank_mc #(
    parameter int REGA_BITS = 14,
    parameter int REGD_BITS = 32,
    parameter int NUM_CH    = 4,
    parameter int CNT_BITS  = 16,
    parameter int FLAG_BITS = 6,
    parameter logic [2*NUM_CH-1:0] RXEQ_RST = 8'h0A,
    parameter logic [4*NUM_CH-1:0] TXDS_RST = 16'h0066,
    parameter logic [3*NUM_CH-1:0] TXPE_RST = 12'h012
) (
    input  logic                   CLK_IN,
    input  logic                   RESET_IN,
    input  logic                   REQ_IN,
    input  logic                   WRITE_IN,
    input  logic [REGA_BITS-1:0]   ADDR_IN,
    input  logic [REGD_BITS-1:0]   WRITE_DATA_IN,
    output logic                   ACK_OUT,
    output logic                   ERR_OUT,
    output logic [REGD_BITS-1:0]   READ_DATA_OUT,
    input  logic [REGD_BITS-1:0]   VERSION_IN,
    input  logic [FLAG_BITS-1:0]   FLAGS_IN,
    input  logic [NUM_CH-1:0]      ERR_PULSE_IN,
    output logic [31:0]            SPINNAKER_LINK_ENABLE,
    output logic [31:0]            PERIPH_MC_KEY,
    output logic [31:0]            PERIPH_MC_MASK,
    output logic [3:0]             SCRMBL_IDL_DAT,
    output logic [2*NUM_CH-1:0]    LED_OVERRIDE,
    output logic [2*NUM_CH-1:0]    RXEQMIX,
    output logic [4*NUM_CH-1:0]    TXDIFFCTRL,
    output logic [3*NUM_CH-1:0]    TXPREEMPHASIS
);

    typedef enum logic [1:0] {UNLOCKED = 2'd0, LOCKED = 2'd1, KEY1 = 2'd2} lock_state_t;

    lock_state_t lock_state, lock_next;

    logic [31:0]          pkey, pmsk, slen;
    logic [3:0]           scrm;
    logic [2*NUM_CH-1:0]  ledo;
    logic [2*NUM_CH-1:0]  rxeq;
    logic [4*NUM_CH-1:0]  txds;
    logic [3*NUM_CH-1:0]  txpe;
    logic [2*NUM_CH-1:0]  rxeq_rd;
    logic [4*NUM_CH-1:0]  txds_rd;
    logic [3*NUM_CH-1:0]  txpe_rd;
    logic [CNT_BITS-1:0]  err_cnt [NUM_CH];
    logic [NUM_CH-1:0]    errc_clr;
    logic                 dirty;

    logic [REGA_BITS-3:0] ch_idx;
    logic ch_hit, ch_cfg_hit, ch_errc_hit;
    logic is_vers, is_flag, is_pkey, is_pmsk, is_scrm, is_slen, is_ledo, is_lock, is_cmt;
    logic prot_hit, ro_hit, mapped, unlocked, key_ok, wr_en, resp_err;
    logic [REGD_BITS-1:0] rd_data;

    // Channel block starts at word 16; each channel owns four consecutive words.
    assign ch_idx      = ADDR_IN[REGA_BITS-1:2] - (REGA_BITS-2)'(4);
    assign ch_hit      = (ADDR_IN >= REGA_BITS'(16)) && (ch_idx < (REGA_BITS-2)'(NUM_CH));
    assign ch_cfg_hit  = ch_hit && (ADDR_IN[1:0] != 2'd3);
    assign ch_errc_hit = ch_hit && (ADDR_IN[1:0] == 2'd3);

    assign is_vers = (ADDR_IN == REGA_BITS'(0));
    assign is_flag = (ADDR_IN == REGA_BITS'(1));
    assign is_pkey = (ADDR_IN == REGA_BITS'(2));
    assign is_pmsk = (ADDR_IN == REGA_BITS'(3));
    assign is_scrm = (ADDR_IN == REGA_BITS'(4));
    assign is_slen = (ADDR_IN == REGA_BITS'(5));
    assign is_ledo = (ADDR_IN == REGA_BITS'(6));
    assign is_lock = (ADDR_IN == REGA_BITS'(7));

`ifdef SHADOW_COMMIT_EN
    logic [2*NUM_CH-1:0] rxeq_sh;
    logic [4*NUM_CH-1:0] txds_sh;
    logic [3*NUM_CH-1:0] txpe_sh;
    assign is_cmt  = (ADDR_IN == REGA_BITS'(8));
    assign rxeq_rd = rxeq_sh;
    assign txds_rd = txds_sh;
    assign txpe_rd = txpe_sh;
    assign dirty   = (rxeq_sh != rxeq) || (txds_sh != txds) || (txpe_sh != txpe);
`else
    assign is_cmt  = 1'b0;
    assign rxeq_rd = rxeq;
    assign txds_rd = txds;
    assign txpe_rd = txpe;
    assign dirty   = 1'b0;
`endif

    assign unlocked = (lock_state == UNLOCKED);
    assign prot_hit = is_pkey | is_pmsk | is_scrm | is_slen | is_ledo | is_cmt | ch_cfg_hit;
    assign ro_hit   = is_vers | is_flag | ch_errc_hit;
    assign mapped   = prot_hit | ro_hit | is_lock;
    assign wr_en    = REQ_IN & WRITE_IN & prot_hit & unlocked;

    always_ff @(posedge CLK_IN or posedge RESET_IN) begin
        if (RESET_IN) lock_state <= UNLOCKED;
        else          lock_state <= lock_next;
    end

    // In KEY1 any accepted request other than the final key falls back to LOCKED.
    always_comb begin
        lock_next = lock_state;
        resp_err  = 1'b0;
        case (lock_state)
            UNLOCKED: key_ok = (WRITE_DATA_IN[31:0] == 32'hA5A5_0001);
            LOCKED:   key_ok = (WRITE_DATA_IN[31:0] == 32'h5A5A_CAFE);
            default:  key_ok = (WRITE_DATA_IN[31:0] == 32'h0000_BEEF);
        endcase
        if (REQ_IN) begin
            if (lock_state == KEY1)
                lock_next = (WRITE_IN && is_lock && key_ok) ? UNLOCKED : LOCKED;
            else if (WRITE_IN && is_lock)
                lock_next = !key_ok ? LOCKED : (unlocked ? LOCKED : KEY1);
            resp_err = !mapped ||
                       (WRITE_IN && (ro_hit || (prot_hit && !unlocked) || (is_lock && !key_ok)));
        end
    end

    always_comb begin
        rd_data  = '0;
        errc_clr = '0;
        if (is_vers)      rd_data = VERSION_IN;
        else if (is_flag) rd_data[FLAG_BITS-1:0] = FLAGS_IN;
        else if (is_pkey) rd_data[31:0] = pkey;
        else if (is_pmsk) rd_data[31:0] = pmsk;
        else if (is_scrm) rd_data[3:0] = scrm;
        else if (is_slen) rd_data[31:0] = slen;
        else if (is_ledo) rd_data[2*NUM_CH-1:0] = ledo;
        else if (is_lock) rd_data[1:0] = lock_state;
        else if (is_cmt)  rd_data[0] = dirty;
        else if (ch_hit) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (ch_idx == (REGA_BITS-2)'(c)) begin
                    case (ADDR_IN[1:0])
                        2'd0:    rd_data[1:0] = rxeq_rd[2*c +: 2];
                        2'd1:    rd_data[3:0] = txds_rd[4*c +: 4];
                        2'd2:    rd_data[2:0] = txpe_rd[3*c +: 3];
                        default: rd_data[CNT_BITS-1:0] = err_cnt[c];
                    endcase
                    errc_clr[c] = REQ_IN && !WRITE_IN && ch_errc_hit;
                end
            end
        end
        else rd_data = '1;
    end

    always_ff @(posedge CLK_IN or posedge RESET_IN) begin
        if (RESET_IN) begin
            pkey <= '1;
            pmsk <= '0;
            scrm <= 4'hF;
            slen <= '0;
            ledo <= {{NUM_CH{1'b0}}, {NUM_CH{1'b1}}};
            rxeq <= RXEQ_RST;
            txds <= TXDS_RST;
            txpe <= TXPE_RST;
`ifdef SHADOW_COMMIT_EN
            rxeq_sh <= RXEQ_RST;
            txds_sh <= TXDS_RST;
            txpe_sh <= TXPE_RST;
`endif
        end else if (wr_en) begin
            if (is_pkey) pkey <= WRITE_DATA_IN[31:0];
            if (is_pmsk) pmsk <= WRITE_DATA_IN[31:0];
            if (is_scrm) scrm <= WRITE_DATA_IN[3:0];
            if (is_slen) slen <= WRITE_DATA_IN[31:0];
            if (is_ledo) ledo <= WRITE_DATA_IN[2*NUM_CH-1:0];
            for (int c = 0; c < NUM_CH; c++) begin
                if (ch_cfg_hit && ch_idx == (REGA_BITS-2)'(c)) begin
`ifdef SHADOW_COMMIT_EN
                    if (ADDR_IN[1:0] == 2'd0) rxeq_sh[2*c +: 2] <= WRITE_DATA_IN[1:0];
                    if (ADDR_IN[1:0] == 2'd1) txds_sh[4*c +: 4] <= WRITE_DATA_IN[3:0];
                    if (ADDR_IN[1:0] == 2'd2) txpe_sh[3*c +: 3] <= WRITE_DATA_IN[2:0];
`else
                    if (ADDR_IN[1:0] == 2'd0) rxeq[2*c +: 2] <= WRITE_DATA_IN[1:0];
                    if (ADDR_IN[1:0] == 2'd1) txds[4*c +: 4] <= WRITE_DATA_IN[3:0];
                    if (ADDR_IN[1:0] == 2'd2) txpe[3*c +: 3] <= WRITE_DATA_IN[2:0];
`endif
                end
            end
`ifdef SHADOW_COMMIT_EN
            if (is_cmt) begin
                rxeq <= rxeq_sh;
                txds <= txds_sh;
                txpe <= txpe_sh;
            end
`endif
        end
    end

    // A pulse coinciding with the clearing read restarts the count at one.
    always_ff @(posedge CLK_IN or posedge RESET_IN) begin
        if (RESET_IN) begin
            for (int c = 0; c < NUM_CH; c++) err_cnt[c] <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (errc_clr[c])
                    err_cnt[c] <= CNT_BITS'(ERR_PULSE_IN[c]);
                else if (ERR_PULSE_IN[c] && (err_cnt[c] != '1))
                    err_cnt[c] <= err_cnt[c] + CNT_BITS'(1);
            end
        end
    end

    always_ff @(posedge CLK_IN or posedge RESET_IN) begin
        if (RESET_IN) begin
            ACK_OUT       <= 1'b0;
            ERR_OUT       <= 1'b0;
            READ_DATA_OUT <= '0;
        end else begin
            ACK_OUT <= REQ_IN;
            ERR_OUT <= REQ_IN & resp_err;
            if (REQ_IN) READ_DATA_OUT <= WRITE_IN ? '0 : rd_data;
        end
    end

    assign SPINNAKER_LINK_ENABLE = slen;
    assign PERIPH_MC_KEY         = pkey;
    assign PERIPH_MC_MASK        = pmsk;
    assign SCRMBL_IDL_DAT        = scrm;
    assign LED_OVERRIDE          = ledo;
    assign RXEQMIX               = rxeq;
    assign TXDIFFCTRL            = txds;
    assign TXPREEMPHASIS         = txpe;

endmodule

// File: tb/tb_spio_ctrl_reg_bank_mc.sv
// Directed self-checking bench for spio_ctrl_reg_bank_mc (default 4-channel configuration).
module tb_spio_ctrl_reg_bank_mc;

    localparam logic [31:0] VERS = 32'h0102_0304;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        reqIn = 1'b0;
    logic        writeIn = 1'b0;
    logic [13:0] addrIn = '0;
    logic [31:0] writeDataIn = '0;
    logic        ackOut, errOut;
    logic [31:0] readDataOut;
    logic [31:0] versionIn = VERS;
    logic [5:0]  flagsIn = 6'h2A;
    logic [3:0]  errPulseIn = '0;
    logic [31:0] linkEnable, periphKey, periphMask;
    logic [3:0]  scrmbl;
    logic [7:0]  ledOverride, rxeqmix;
    logic [15:0] txdiffctrl;
    logic [11:0] txpreemph;

    int compareCount = 0;
    int mismatchCount = 0;
    logic [31:0] rd;
    logic        er;

    spio_ctrl_reg_bank_mc dut (
        .CLK_IN(clock), .RESET_IN(reset), .REQ_IN(reqIn), .WRITE_IN(writeIn),
        .ADDR_IN(addrIn), .WRITE_DATA_IN(writeDataIn), .ACK_OUT(ackOut), .ERR_OUT(errOut),
        .READ_DATA_OUT(readDataOut), .VERSION_IN(versionIn), .FLAGS_IN(flagsIn),
        .ERR_PULSE_IN(errPulseIn), .SPINNAKER_LINK_ENABLE(linkEnable),
        .PERIPH_MC_KEY(periphKey), .PERIPH_MC_MASK(periphMask), .SCRMBL_IDL_DAT(scrmbl),
        .LED_OVERRIDE(ledOverride), .RXEQMIX(rxeqmix), .TXDIFFCTRL(txdiffctrl),
        .TXPREEMPHASIS(txpreemph)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
        end
    endtask

    // One bus access: request driven on a falling edge, response sampled on the next one.
    task automatic applyStimulus(input logic wr, input logic [13:0] addr, input logic [31:0] data,
                                 input logic [3:0] pulse, output logic [31:0] rdata, output logic err);
        @(negedge clock);
        reqIn = 1'b1; writeIn = wr; addrIn = addr; writeDataIn = data; errPulseIn = pulse;
        @(negedge clock);
        reqIn = 1'b0; writeIn = 1'b0; errPulseIn = '0;
        checkOutput("ack", 32'(ackOut), 32'd1);
        rdata = readDataOut;
        err = errOut;
    endtask

    initial begin
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        checkOutput("ack_reset", 32'(ackOut), 32'd0);
        checkOutput("rdata_reset", readDataOut, 32'd0);
        checkOutput("key_reset", periphKey, 32'hFFFF_FFFF);
        checkOutput("led_reset", 32'(ledOverride), 32'h0F);

        applyStimulus(1'b0, 14'd0, 32'd0, 4'd0, rd, er);  checkOutput("rd_vers", rd, VERS);
        checkOutput("rd_vers_err", 32'(er), 32'd0);
        applyStimulus(1'b0, 14'd1, 32'd0, 4'd0, rd, er);  checkOutput("rd_flag", rd, 32'h2A);
        applyStimulus(1'b0, 14'd2, 32'd0, 4'd0, rd, er);  checkOutput("rd_pkey", rd, 32'hFFFF_FFFF);
        applyStimulus(1'b0, 14'd6, 32'd0, 4'd0, rd, er);  checkOutput("rd_ledo", rd, 32'h0000_000F);
        applyStimulus(1'b0, 14'd16, 32'd0, 4'd0, rd, er); checkOutput("rd_rxeq0", rd, 32'd2);
        applyStimulus(1'b0, 14'd17, 32'd0, 4'd0, rd, er); checkOutput("rd_txds0", rd, 32'd6);
        applyStimulus(1'b0, 14'd18, 32'd0, 4'd0, rd, er); checkOutput("rd_txpe0", rd, 32'd2);
        @(negedge clock);
        checkOutput("ack_idle", 32'(ackOut), 32'd0);

        applyStimulus(1'b1, 14'd20, 32'h3, 4'd0, rd, er); checkOutput("wr_rxeq1_err", 32'(er), 32'd0);
        applyStimulus(1'b1, 14'd21, 32'hA, 4'd0, rd, er);
        applyStimulus(1'b1, 14'd22, 32'h5, 4'd0, rd, er);
        applyStimulus(1'b0, 14'd21, 32'd0, 4'd0, rd, er); checkOutput("rd_txds1", rd, 32'hA);
`ifdef SHADOW_COMMIT_EN
        checkOutput("rxeq_staged", 32'(rxeqmix), 32'h0A);
        checkOutput("txds_staged", 32'(txdiffctrl), 32'h0066);
        applyStimulus(1'b0, 14'd8, 32'd0, 4'd0, rd, er);  checkOutput("rd_commit_dirty", rd, 32'd1);
        applyStimulus(1'b1, 14'd8, 32'd0, 4'd0, rd, er);  checkOutput("wr_commit_err", 32'(er), 32'd0);
`else
        applyStimulus(1'b0, 14'd8, 32'd0, 4'd0, rd, er);  checkOutput("rd_addr8", rd, 32'hFFFF_FFFF);
        checkOutput("rd_addr8_err", 32'(er), 32'd1);
`endif
        checkOutput("rxeqmix", 32'(rxeqmix), 32'h0E);
        checkOutput("txdiffctrl", 32'(txdiffctrl), 32'h00A6);
        checkOutput("txpreemph", 32'(txpreemph), 32'h02A);

        @(negedge clock); errPulseIn = 4'b0100;
        repeat (5) @(negedge clock);
        errPulseIn = '0;
        applyStimulus(1'b0, 14'd27, 32'd0, 4'd0, rd, er); checkOutput("errc_5", rd, 32'd5);
        applyStimulus(1'b0, 14'd27, 32'd0, 4'd0, rd, er); checkOutput("errc_cleared", rd, 32'd0);
        applyStimulus(1'b0, 14'd27, 32'd0, 4'b0100, rd, er); checkOutput("errc_coincide", rd, 32'd0);
        applyStimulus(1'b0, 14'd27, 32'd0, 4'd0, rd, er); checkOutput("errc_kept", rd, 32'd1);
        @(negedge clock); errPulseIn = 4'b0100;
        repeat (65539) @(negedge clock);
        errPulseIn = '0;
        applyStimulus(1'b0, 14'd27, 32'd0, 4'd0, rd, er); checkOutput("errc_sat", rd, 32'h0000_FFFF);
        applyStimulus(1'b0, 14'd23, 32'd0, 4'd0, rd, er); checkOutput("errc_ch1", rd, 32'd0);

        applyStimulus(1'b1, 14'd7, 32'hA5A5_0001, 4'd0, rd, er); checkOutput("lock_err", 32'(er), 32'd0);
        applyStimulus(1'b1, 14'd2, 32'h1234, 4'd0, rd, er); checkOutput("locked_wr_err", 32'(er), 32'd1);
        checkOutput("locked_key", periphKey, 32'hFFFF_FFFF);
        applyStimulus(1'b1, 14'd7, 32'h5A5A_CAFE, 4'd0, rd, er); checkOutput("key1_err", 32'(er), 32'd0);
        applyStimulus(1'b0, 14'd0, 32'd0, 4'd0, rd, er);
        applyStimulus(1'b1, 14'd7, 32'h0000_BEEF, 4'd0, rd, er); checkOutput("late_beef_err", 32'(er), 32'd1);
        applyStimulus(1'b0, 14'd7, 32'd0, 4'd0, rd, er); checkOutput("lock_state_1", rd, 32'd1);
        applyStimulus(1'b1, 14'd7, 32'h5A5A_CAFE, 4'd0, rd, er);
        applyStimulus(1'b0, 14'd7, 32'd0, 4'd0, rd, er); checkOutput("lock_state_2", rd, 32'd2);
        applyStimulus(1'b0, 14'd7, 32'd0, 4'd0, rd, er); checkOutput("lock_back_1", rd, 32'd1);
        applyStimulus(1'b1, 14'd7, 32'h5A5A_CAFE, 4'd0, rd, er);
        applyStimulus(1'b1, 14'd7, 32'h0000_BEEF, 4'd0, rd, er); checkOutput("unlock_err", 32'(er), 32'd0);
        applyStimulus(1'b0, 14'd7, 32'd0, 4'd0, rd, er); checkOutput("lock_state_0", rd, 32'd0);
        applyStimulus(1'b1, 14'd2, 32'h1234, 4'd0, rd, er); checkOutput("unlocked_wr_err", 32'(er), 32'd0);
        checkOutput("unlocked_key", periphKey, 32'h1234);

        applyStimulus(1'b0, 14'd1000, 32'd0, 4'd0, rd, er); checkOutput("unmapped_rd", rd, 32'hFFFF_FFFF);
        checkOutput("unmapped_err", 32'(er), 32'd1);
        applyStimulus(1'b1, 14'd0, 32'h5, 4'd0, rd, er); checkOutput("ro_wr_err", 32'(er), 32'd1);
        applyStimulus(1'b0, 14'd0, 32'd0, 4'd0, rd, er); checkOutput("ro_unchanged", rd, VERS);

        // Four back-to-back reads; the next address is presented as each ACK is checked.
        begin
            logic [13:0] addrs [4];
            logic [31:0] exps [4];
            addrs = '{14'd0, 14'd2, 14'd4, 14'd5};
            exps  = '{VERS, 32'h1234, 32'hF, 32'h0};
            @(negedge clock);
            reqIn = 1'b1; writeIn = 1'b0; addrIn = addrs[0];
            for (int i = 0; i < 4; i++) begin
                @(negedge clock);
                checkOutput("b2b_ack", 32'(ackOut), 32'd1);
                checkOutput("b2b_data", readDataOut, exps[i]);
                if (i < 3) addrIn = addrs[i+1];
                else reqIn = 1'b0;
            end
        end

        applyStimulus(1'b1, 14'd3, 32'hFF00, 4'd0, rd, er);
        applyStimulus(1'b1, 14'd4, 32'h3, 4'd0, rd, er);
        applyStimulus(1'b1, 14'd5, 32'h1234_5678, 4'd0, rd, er);
        applyStimulus(1'b1, 14'd6, 32'hA5, 4'd0, rd, er);
        checkOutput("ledo_written", 32'(ledOverride), 32'hA5);
        applyStimulus(1'b1, 14'd7, 32'hA5A5_0001, 4'd0, rd, er);

        @(negedge clock);
        reqIn = 1'b1; writeIn = 1'b1; addrIn = 14'd2; writeDataIn = 32'hDEAD_0000;
        #2 reset = 1'b1;
        @(posedge clock); #1;
        checkOutput("rst_ack", 32'(ackOut), 32'd0);
        checkOutput("rst_key", periphKey, 32'hFFFF_FFFF);
        checkOutput("rst_mask", periphMask, 32'd0);
        checkOutput("rst_scrm", 32'(scrmbl), 32'hF);
        checkOutput("rst_slen", linkEnable, 32'd0);
        checkOutput("rst_ledo", 32'(ledOverride), 32'h0F);
        checkOutput("rst_rxeq", 32'(rxeqmix), 32'h0A);
        checkOutput("rst_txds", 32'(txdiffctrl), 32'h0066);
        checkOutput("rst_txpe", 32'(txpreemph), 32'h012);
        @(negedge clock);
        reqIn = 1'b0; writeIn = 1'b0; reset = 1'b0;
        @(negedge clock);
        checkOutput("rst_no_late_ack", 32'(ackOut), 32'd0);
        applyStimulus(1'b1, 14'd2, 32'h77, 4'd0, rd, er); checkOutput("rst_unlocked_err", 32'(er), 32'd0);
        checkOutput("rst_unlocked_key", periphKey, 32'h77);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
